operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Clocked front-end that turns raw SWITCH/button activity into clean, one-shot writes of the A, B and C operand/config registers.
- It is the writer side of the register interface that the ALU, LED mux and 7-segment display path read from.
- It replaces level-sensitive button capture with synchronized, debounced, edge-qualified loads.
- Each valid press gives exactly one register write plus a one-cycle strobe.

Parameters:
- N, 10, width of A and B registers; legal 1..10; loads take SWITCH[N-1:0].
- DEBOUNCE, 4, consecutive stable clock cycles required before a button-vector change is accepted; legal >= 2.
- CNT_W, 16, width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SWITCH  input  10  raw switch levels; asynchronous to clk.
- B0  input  1  raw button, active-high; requests load of A.
- B1  input  1  raw button, active-high; requests load of B.
- B2  input  1  raw button, active-high; requests load of C.
- a_out  output  N  A register.
- b_out  output  N  B register.
- c_out  output  10  C register (config word: HEX_mode[9:8], HEX_show[7:6], LED_show[5:4], carry_in[3], ALU_op[2:0]).
- load_strobe  output  3  one-hot, one cycle, asserted in the cycle the register is written; bit0=A, bit1=B, bit2=C.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst_n low, async): a_out=0, b_out=0, c_out=0, load_strobe=0, busy=0. Sync flops, debounce counter, debounced vector and FSM (IDLE) are all cleared. Reset asserted mid-operation aborts immediately, and no write occurs on the release edge.
- Synchronization: {B2,B1,B0} and SWITCH each pass through 2 flops. Only synchronized values are used downstream.
- Debounce:
  - cnt resets to 0 on any cycle where the synced button vector differs from its previous-cycle value; otherwise it increments, saturating at DEBOUNCE.
  - The debounced vector db takes the synced vector on the edge cnt reaches DEBOUNCE.
  - Glitches shorter than DEBOUNCE cycles never reach db.
- FSM states IDLE, LOAD, HOLD:
  - IDLE: db one-hot goes to LOAD. db=000 or any multi-bit value stays in IDLE (chords are ignored; see Optional Feature).
  - LOAD: lasts exactly one cycle. Writes the selected register from synced SWITCH (A/B: SWITCH[N-1:0]; C: all 10 bits), asserts the matching load_strobe bit, then goes to HOLD.
  - HOLD: stays until db=000, then goes to IDLE. Pressing another button while holding does nothing. A full release (debounced) is required before the next load.
- Latency: a clean button rise first sampled at edge k gives the register update and strobe at edge k+DEBOUNCE+3. Switch value used is the synced SWITCH at the LOAD edge.
- A button held through reset deassertion is treated as a fresh press: one load after debounce.
- Non-selected registers hold their value. load_strobe is never multi-hot and never high two cycles in a row.

Optional Feature:
- Macro OPERAND_LOADER_CHORD_CLEAR_EN.
- Defined: in IDLE, db=111 goes to LOAD-clear, which sets a_out=b_out=c_out=0 in one cycle, pulses load_strobe=111, then goes to HOLD.
- Undefined: 111 is ignored like any other chord, and load_strobe is strictly one-hot.

Test Plan (DEBOUNCE=4, N=10):
- SWITCH=0x2A5, B0 held 10 cycles then released -> a_out=0x2A5 exactly 7 edges after B0 first sampled, load_strobe=001 for 1 cycle, b_out/c_out stay 0, busy high from LOAD until db clears.
- B1 bounce pattern 1,0,1,0,1 (1-cycle pulses), then steady 1 with SWITCH=0x00F -> exactly one load, b_out=0x00F, single strobe 010.
- B2 held and SWITCH changed 0x155->0x0AA during HOLD -> c_out=0x155 only, no second strobe; release then re-press -> c_out=0x0AA.
- B0+B1 pressed together -> no register change, load_strobe stays 0. With OPERAND_LOADER_CHORD_CLEAR_EN, B0+B1+B2 from A=0x3FF -> all registers 0, strobe 111 once.
- rst_n pulsed low during debounce of B0 press (SWITCH=0x123) -> all outputs 0 immediately. If B0 is still held after reset, a_out=0x123 at DEBOUNCE+3 edges after reset release.
- N=4, SWITCH=0x3F7, B1 press -> b_out=0x7.

Source files
------------

// File: rtl/operand_loader.sv
// operand_loader: switch/button front-end that writes the A, B and C
// operand/config registers once per debounced button press.
// Buttons and switches are double-flopped into clk. The button vector is
// debounced as a whole. A three-state FSM (IDLE/LOAD/HOLD) turns each
// accepted one-hot press into exactly one register write and a one-cycle
// strobe, and it needs a full debounced release before the next press.
// Optional build macro: OPERAND_LOADER_CHORD_CLEAR_EN. When it is defined,
// a debounced B0+B1+B2 chord clears all three registers and pulses
// load_strobe=111.
module operand_loader #(
    parameter int N        = 10,
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [9:0]   SWITCH,
    input  logic         B0,
    input  logic         B1,
    input  logic         B2,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic [9:0]   c_out,
    output logic [2:0]   load_strobe,
    output logic         busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [2:0]       btn_meta_reg, btn_sync_reg, btn_prev_reg, db_reg;
    logic [9:0]       sw_meta_reg, sw_sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    state_t           state_reg, state_next;
    logic [2:0]       sel_reg, sel_next;
    logic             load_en, clear_en;
    logic [N-1:0]     a_reg, b_reg;
    logic [9:0]       c_reg;
    logic             db_onehot;

    // Two-flop synchronizers for the raw buttons and switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
        end else begin
            btn_meta_reg <= {B2, B1, B0};
            btn_sync_reg <= btn_meta_reg;
            sw_meta_reg  <= SWITCH;
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    // Debounce: any change in the synced vector restarts the count. db
    // takes the vector on the edge where the count reaches DEBOUNCE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_reg <= '0;
            cnt_reg      <= '0;
            db_reg       <= '0;
        end else begin
            btn_prev_reg <= btn_sync_reg;
            if (btn_sync_reg != btn_prev_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg < CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_ONE;
                if (cnt_reg == CNT_MAX - CNT_ONE) begin
                    db_reg <= btn_sync_reg;
                end
            end
        end
    end

    assign db_onehot = (db_reg == 3'b001) || (db_reg == 3'b010) || (db_reg == 3'b100);

    // FSM state and selected-register registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    // Next-state logic. The write happens on the edge that enters LOAD,
    // so the strobe decoded from LOAD lines up with the new register value.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        load_en    = 1'b0;
        clear_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (db_onehot) begin
                    state_next = ST_LOAD;
                    sel_next   = db_reg;
                    load_en    = 1'b1;
                end
`ifdef OPERAND_LOADER_CHORD_CLEAR_EN
                else if (db_reg == 3'b111) begin
                    state_next = ST_LOAD;
                    sel_next   = 3'b111;
                    clear_en   = 1'b1;
                end
`endif
            end
            ST_LOAD: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (db_reg == 3'b000) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand/config registers. Only the selected register is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
        end else if (clear_en) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
        end else if (load_en) begin
            if (db_reg[0]) a_reg <= sw_sync_reg[N-1:0];
            if (db_reg[1]) b_reg <= sw_sync_reg[N-1:0];
            if (db_reg[2]) c_reg <= sw_sync_reg;
        end
    end

    assign a_out       = a_reg;
    assign b_out       = b_reg;
    assign c_out       = c_reg;
    assign load_strobe = (state_reg == ST_LOAD) ? sel_reg : 3'b000;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed and random button/switch stimulus for two
// operand_loader instances (N=10 and N=4). The reference model works on the
// history of sampled inputs. A button value is accepted once it has been
// sampled DEBOUNCE+1 times in a row. A write then needs an armed loader,
// and a full release re-arms the loader.
module tb_operand_loader;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [9:0] SWITCH;
    logic [2:0] btn;

    logic [9:0] a_out, b_out, c_out;
    logic [2:0] load_strobe;
    logic       busy;
    logic [3:0] a4, b4;
    logic [9:0] c4;
    logic [2:0] stb4;
    logic       busy4;

    operand_loader #(.N(10), .DEBOUNCE(DEB), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .SWITCH(SWITCH),
        .B0(btn[0]), .B1(btn[1]), .B2(btn[2]),
        .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .load_strobe(load_strobe), .busy(busy)
    );

    operand_loader #(.N(4), .DEBOUNCE(DEB), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .SWITCH(SWITCH),
        .B0(btn[0]), .B1(btn[1]), .B2(btn[2]),
        .a_out(a4), .b_out(b4), .c_out(c4),
        .load_strobe(stb4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Sampled input history, one entry per rising edge since reset release.
    logic [2:0] bh[$];
    logic [9:0] sh[$];

    // Reference model state.
    logic [2:0] db_m;
    logic [2:0] stb_m;
    logic [9:0] a_m, b_m, c_m;
    bit         armed_m;     // a press may write
    bit         loading_m;   // the strobe cycle is in progress
    bit         busy_m;

    function automatic logic [2:0] bsamp(input int i);
        if (i < 0) return 3'b000;
        return bh[i];
    endfunction

    function automatic logic [9:0] ssamp(input int i);
        if (i < 0) return 10'h000;
        return sh[i];
    endfunction

    task automatic model_reset();
        bh.delete();
        sh.delete();
        db_m = 0; stb_m = 0; a_m = 0; b_m = 0; c_m = 0;
        armed_m = 1; loading_m = 0; busy_m = 0;
    endtask

    // Advance the model by one rising edge. The newest sample is bh[e].
    task automatic model_edge();
        int         e;
        bit         stable;
        logic [2:0] db_old;
        logic [9:0] sw_use;
        e      = bh.size() - 1;
        db_old = db_m;
        sw_use = ssamp(e - 2);
        stable = 1;
        for (int j = 1; j <= DEB; j++)
            if (bsamp(e - 2 - j) != bsamp(e - 2)) stable = 0;
        if (stable) db_m = bsamp(e - 2);
        stb_m = 0;
        if (loading_m) begin
            loading_m = 0;
        end else if (armed_m && $onehot(db_old)) begin
            if (db_old[0]) a_m = sw_use;
            if (db_old[1]) b_m = sw_use;
            if (db_old[2]) c_m = sw_use;
            stb_m = db_old; armed_m = 0; loading_m = 1;
`ifdef OPERAND_LOADER_CHORD_CLEAR_EN
        end else if (armed_m && db_old == 3'b111) begin
            a_m = 0; b_m = 0; c_m = 0;
            stb_m = 3'b111; armed_m = 0; loading_m = 1;
`endif
        end else if (!armed_m && db_old == 3'b000) begin
            armed_m = 1;
        end
        busy_m = !armed_m;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_out", a_out, a_m);
        chk("b_out", b_out, b_m);
        chk("c_out", c_out, c_m);
        chk("load_strobe", {7'b0, load_strobe}, {7'b0, stb_m});
        chk("busy", {9'b0, busy}, {9'b0, busy_m});
        chk("n4_a_out", {6'b0, a4}, {6'b0, a_m[3:0]});
        chk("n4_b_out", {6'b0, b4}, {6'b0, b_m[3:0]});
        chk("n4_strobe", {7'b0, stb4}, {7'b0, stb_m});
    endtask

    // Drive one cycle of inputs, take the edge, update the model and compare.
    task automatic step(input logic [2:0] b, input logic [9:0] sw);
        btn    = b;
        SWITCH = sw;
        @(posedge clk);
        bh.push_back(b);
        sh.push_back(sw);
        model_edge();
        #1;
        check_all();
        $display("edge %0d btn=%b sw=%h a=%h b=%h c=%h stb=%b busy=%b",
                 bh.size() - 1, b, sw, a_out, b_out, c_out, load_strobe, busy);
    endtask

    task automatic steps(input int n, input logic [2:0] b, input logic [9:0] sw);
        for (int i = 0; i < n; i++) step(b, sw);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        btn    = 3'b000;
        SWITCH = 10'h000;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        chk("reset_a", a_out, 10'h000);
        chk("reset_b", b_out, 10'h000);
        chk("reset_c", c_out, 10'h000);
        chk("reset_strobe", {7'b0, load_strobe}, 10'h000);
        chk("reset_busy", {9'b0, busy}, 10'h000);
        rst_n = 1'b1;

        // Clean B0 press loads A.
        steps(10, 3'b001, 10'h2A5);
        steps(12, 3'b000, 10'h2A5);
        chk("A_loaded", a_out, 10'h2A5);

        // Bouncing B1, then steady: exactly one load.
        step(3'b010, 10'h00F); step(3'b000, 10'h00F);
        step(3'b010, 10'h00F); step(3'b000, 10'h00F);
        steps(10, 3'b010, 10'h00F);
        steps(12, 3'b000, 10'h00F);
        chk("B_loaded", b_out, 10'h00F);

        // B2 held while SWITCH changes: first value only; re-press picks up new.
        steps(9, 3'b100, 10'h155);
        steps(6, 3'b100, 10'h0AA);
        steps(12, 3'b000, 10'h0AA);
        chk("C_first", c_out, 10'h155);
        steps(10, 3'b100, 10'h0AA);
        steps(12, 3'b000, 10'h0AA);
        chk("C_second", c_out, 10'h0AA);

        // Two-button chord: ignored.
        steps(10, 3'b011, 10'h3C3);
        steps(12, 3'b000, 10'h3C3);

        // Load A=0x3FF, then the three-button chord.
        steps(10, 3'b001, 10'h3FF);
        steps(12, 3'b000, 10'h3FF);
        steps(10, 3'b111, 10'h3FF);
        steps(12, 3'b000, 10'h3FF);

        // N=4 instance takes only the low switch bits.
        steps(10, 3'b010, 10'h3F7);
        steps(12, 3'b000, 10'h3F7);
        chk("n4_B_low_bits", {6'b0, b4}, 10'h007);

        // Reset during debounce of a B0 press, button still held afterwards.
        steps(3, 3'b001, 10'h123);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a", a_out, 10'h000);
        chk("midrst_b", b_out, 10'h000);
        chk("midrst_c", c_out, 10'h000);
        chk("midrst_busy", {9'b0, busy}, 10'h000);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        steps(10, 3'b001, 10'h123);
        steps(12, 3'b000, 10'h123);
        chk("post_reset_A", a_out, 10'h123);

        // Random presses, glitches and chords of random length.
        for (int it = 0; it < 40; it++) begin
            logic [2:0] rb;
            logic [9:0] rs;
            int         len;
            rb  = 3'($urandom_range(0, 7));
            rs  = 10'($urandom);
            len = $urandom_range(1, 12);
            steps(len, rb, rs);
        end
        steps(12, 3'b000, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
